// File: rtl/instruction_predecoder_unit_pkg.sv
// Shared control-flow predecode definitions: group opcode, field positions,
// selector codes and the combinational decode used by fetch-side stages.
package instruction_predecoder_unit_pkg;

  localparam logic [5:0]  GROUP_OPCODE = 6'b100000;
  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 26;
  localparam int unsigned SEL_MSB      = 25;
  localparam int unsigned SEL_LSB      = 22;
  localparam int unsigned GROUP_BIT    = 21;

  typedef enum logic [3:0] {
    SEL_JMP = 4'b0000,
    SEL_JZE = 4'b0001,
    SEL_JNE = 4'b0010,
    SEL_JOV = 4'b0011,
    SEL_JCY = 4'b0100,
    SEL_RET = 4'b1000,
    SEL_BSR = 4'b1100
  } sel_e;

  typedef struct packed {
    logic jmp;
    logic jze;
    logic jne;
    logic jov;
    logic jcy;
    logic ret;
    logic bsr;
  } flow_t;

  // Takes only the decoded fields so callers never carry the don't-care bits.
  function automatic flow_t predecode(input logic [5:0] opcode,
                                     input logic       group_bit,
                                     input logic [3:0] sel);
    flow_t f;
    f = '0;
    if (opcode == GROUP_OPCODE && group_bit) begin
      case (sel)
        SEL_JMP: f.jmp = 1'b1;
        SEL_JZE: f.jze = 1'b1;
        SEL_JNE: f.jne = 1'b1;
        SEL_JOV: f.jov = 1'b1;
        SEL_JCY: f.jcy = 1'b1;
        SEL_RET: f.ret = 1'b1;
        SEL_BSR: f.bsr = 1'b1;
        default: f = '0;
      endcase
    end
    return f;
  endfunction

endpackage

// File: rtl/instruction_predecoder_unit.sv
// Control-flow predecoder: combinational decode of the fetched word with all
// seven one-hot flags registered, one cycle of latency, no handshake.
module instruction_predecoder_unit
  import instruction_predecoder_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        jmp,
  output logic        jze,
  output logic        jne,
  output logic        jov,
  output logic        jcy,
  output logic        ret,
  output logic        bsr
);

  flow_t decoded;
  flow_t flags;
  logic  unused_operand_bits;

  // Operand/offset bits play no part in control-flow classification.
  assign unused_operand_bits = ^instruction[GROUP_BIT-1:0];

  always_comb begin
    decoded = predecode(instruction[OPCODE_MSB:OPCODE_LSB],
                        instruction[GROUP_BIT],
                        instruction[SEL_MSB:SEL_LSB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else begin
      flags <= decoded;
    end
  end

  assign jmp = flags.jmp;
  assign jze = flags.jze;
  assign jne = flags.jne;
  assign jov = flags.jov;
  assign jcy = flags.jcy;
  assign ret = flags.ret;
  assign bsr = flags.bsr;

endmodule

// File: tb/tb_instruction_predecoder_unit.sv
// Self-checking bench for instruction_predecoder_unit: directed vectors, reset
// behaviour and a randomized sweep against an arithmetic reference decode.
module tb_instruction_predecoder_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        jmp, jze, jne, jov, jcy, ret, bsr;

  int unsigned checks;
  int unsigned errors;

  instruction_predecoder_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .jmp         (jmp),
    .jze         (jze),
    .jne         (jne),
    .jov         (jov),
    .jcy         (jcy),
    .ret         (ret),
    .bsr         (bsr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {jmp,jze,jne,jov,jcy,ret,bsr} from plain integer field extraction.
  function automatic logic [6:0] ref_decode(input int unsigned w);
    int unsigned op;
    int unsigned sel;
    int unsigned grp;
    op  = w / (1 << 26);
    sel = (w / (1 << 22)) % 16;
    grp = (w / (1 << 21)) % 2;
    if (op != 32 || grp != 1) return 7'b0000000;
    case (sel)
      0:       return 7'b1000000;
      1:       return 7'b0100000;
      2:       return 7'b0010000;
      3:       return 7'b0001000;
      4:       return 7'b0000100;
      8:       return 7'b0000010;
      12:      return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [6:0] outs();
    return {jmp, jze, jne, jov, jcy, ret, bsr};
  endfunction

  // Present one word (and rst) for one cycle; outputs are sampled after the edge.
  task automatic drive(input logic [31:0] w, input logic r);
    @(negedge clk);
    instruction = w;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    for (int i = 0; i < 3; i++) begin
      drive(32'h80333300, 1'b1);
      got = outs();
      checks++;
      if (got !== 7'b0000000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got %b expected %b", i, got, 7'b0000000);
      end
    end
    drive(32'h80333300, 1'b0);
    got = outs();
    checks++;
    if (got !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_release got %b expected %b", got, 7'b1000000);
    end
  endtask

  task automatic test_control_flow();
    logic [31:0] words [7];
    logic [6:0]  exp   [7];
    logic [6:0]  got;
    words = '{32'h80333300, 32'h80733300, 32'h80B33300, 32'h80F33300,
              32'h81333300, 32'h82333300, 32'h83333300};
    exp   = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000,
              7'b0000100, 7'b0000010, 7'b0000001};
    for (int i = 0; i < 7; i++) begin
      drive(words[i], 1'b0);
      got = outs();
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL control_flow %h got %b expected %b", words[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_non_group();
    logic [31:0] words [6];
    logic [6:0]  got;
    words = '{32'h70002040, 32'h946AAEC0, 32'hB42AAED6, 32'h00300000,
              32'h80133300, 32'h81733300};
    for (int i = 0; i < 6; i++) begin
      drive(words[i], 1'b0);
      got = outs();
      checks++;
      if (got !== 7'b0000000) begin
        errors++;
        $display("FAIL non_group %h got %b expected %b", words[i], got, 7'b0000000);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] got;
    drive(32'h83333300, 1'b0);
    got = outs();
    checks++;
    if (got !== 7'b0000001) begin
      errors++;
      $display("FAIL b2b_pre got %b expected %b", got, 7'b0000001);
    end
    drive(32'h82333300, 1'b1);
    got = outs();
    checks++;
    if (got !== 7'b0000000) begin
      errors++;
      $display("FAIL midstream_reset got %b expected %b", got, 7'b0000000);
    end
    drive(32'h80733300, 1'b0);
    got = outs();
    checks++;
    if (got !== 7'b0100000) begin
      errors++;
      $display("FAIL post_reset_decode got %b expected %b", got, 7'b0100000);
    end
  endtask

  task automatic test_random_sweep();
    logic [31:0] w;
    logic [6:0]  got;
    logic [6:0]  exp;
    int unsigned bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[31:26] = 6'b100000;
        if ($urandom_range(0, 3) != 0) w[21] = 1'b1;
      end
      drive(w, 1'b0);
      got = outs();
      exp = ref_decode(w);
      checks++;
      if (got !== exp || $countones(got) > 1) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_sweep %h got %b expected %b", w, got, exp);
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    instruction = '0;
    test_reset();
    test_control_flow();
    test_non_group();
    test_back_to_back();
    test_random_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
